i2c_bus_decoder: RTL and testbench
==================================

Name: i2c_bus_decoder

Overview:
Passive I2C bus decoder that oversamples raw SCL/SDA on the system clock. It detects START, repeated START and STOP conditions and tracks frame position using the agreed i2c_fsm_state_e encoding. It emits per-field strobes for slave address, R/W, register address, data bytes and ACK/NACK. It sits between the bus pins and the slave register block and scoreboard, and consumes the global address, width and state definitions.

Parameters:
SLAVE_ADDRESS_WIDTH, 7, slave address bits
REGISTER_ADDRESS_WIDTH, 8, register address bits
DATA_WIDTH, 8, data byte bits
MAXIMUM_BYTES, 128, data bytes per frame before overflow
SLAVE0_ADDRESS..SLAVE3_ADDRESS, 7'h68/7'h6C/7'h7C/7'h4C, match addresses

Ports:
pclk  in  1  system clock; must be at least 8x SCL rate
areset  in  1  asynchronous, active-high reset
scl_i  in  1  raw SCL (asynchronous)
sda_i  in  1  raw SDA (asynchronous)
state_o  out  6  current i2c_fsm_state_e value (codes 0..39)
start_o  out  1  pulse on START or repeated START
restart_o  out  1  pulse on repeated START only
stop_o  out  1  pulse on STOP
slave_addr_o  out  7  captured slave address
rw_o  out  1  0=WRITE, 1=READ
addr_valid_o  out  1  pulse when slave_addr_o and rw_o are updated
slave_sel_o  out  4  one-hot address match, 0 when there is no hit
reg_addr_o  out  8  captured register address
reg_valid_o  out  1  pulse when reg_addr_o is updated
data_o  out  8  captured data byte, MSB first
data_valid_o  out  1  pulse when data_o is updated
byte_cnt_o  out  8  data bytes in the current frame
ack_o  out  1  sampled ACK bit: 0=ACK, 1=NACK
ack_valid_o  out  1  pulse on each ACK-slot sample
bus_error_o  out  1  pulse on STOP or START mid-field
overflow_o  out  1  sticky until the next START

Behaviour:
- Reset: areset asynchronous, active-high. All outputs are 0 except state_o=IDLE(1). Sync flops reset to 1 (bus idle).
- Sampling: scl_i and sda_i each pass through a 2-flop synchronizer, giving scl_s and sda_s. scl_p and sda_p hold the previous scl_s and sda_s values.
- Event detection (all events registered, all pulses 1 cycle):
  - START: scl_s=1, scl_p=1, sda_p=1, sda_s=0.
  - STOP: scl_s=1, scl_p=1, sda_p=0, sda_s=1.
  - SCL rise: scl_p=0, scl_s=1. SDA is sampled from sda_s in the same cycle.
- Latency: pulses and the state_o update are visible after the 3rd pclk rising edge following the raw pin change.
- Simultaneous SCL and SDA change in the same sample: treated as an SCL edge only, never as START or STOP.
- FSM advances only on SCL rise, START or STOP:
  - IDLE/STOP --START--> SLAVE_ADDR_0. Clears byte_cnt and overflow.
  - SLAVE_ADDR_0..6 --rise--> next state, shifting in address bits MSB first.
  - SLAVE_ADDR_6 --rise--> RD_WR.
  - RD_WR --rise--> SLAVE_ADDR_ACK. Captures rw, pulses addr_valid, drives slave_sel.
  - SLAVE_ADDR_ACK --rise--> pulses ack_valid.
    - If ACK and WRITE: go to REG_ADDR_0.
    - If ACK and READ: go to DATA_0.
    - If NACK: hold in SLAVE_ADDR_ACK, ignore further rises until START or STOP.
  - REG_ADDR_0..7 shifts bits in. REG_ADDR_7 --rise--> REG_ADDR_ACK, pulses reg_valid.
  - REG_ADDR_ACK --rise--> DATA_0 on ACK. On NACK, hold as above.
  - DATA_0..7 shifts bits in. DATA_7 --rise--> DATA_ACK, pulses data_valid, increments byte_cnt.
  - DATA_ACK --rise--> DATA_0 on ACK. On NACK, hold (normal end of read).
  - STOP from any non-IDLE state --> STOP (state code 39), pulses stop_o. STOP --next cycle--> IDLE.
  - START in any state other than IDLE/STOP: repeated START. Pulses start_o and restart_o, goes to SLAVE_ADDR_0, clears byte_cnt.
- bus_error: pulses when START or STOP arrives in any SLAVE_ADDR_x, RD_WR, REG_ADDR_x or DATA_1..7 state, alongside the normal transition. START or STOP in DATA_0 or any ACK/hold state is legal.
- Overflow: when byte_cnt reaches MAXIMUM_BYTES, the next byte still pulses data_valid but byte_cnt saturates and overflow_o is set.
- SCL rise in IDLE: ignored. Captured registers hold their value until overwritten.

Test Plan:
- Write frame: START, address 0x68, W, ACK, register 0xA5, ACK, data 0x3C, ACK, STOP -> addr_valid with slave_addr=0x68, rw=0, slave_sel=4'b0001; reg_valid with reg_addr=0xA5; data_valid with data=0x3C; byte_cnt=1; three ack_valid pulses with ack=0; stop_o pulses; state ends IDLE.
- Read with repeated START: write to 0x4C, register 0x10, then rSTART, 0x4C R, two bytes 0x11 and 0x22, NACK on the last, STOP -> restart_o pulses once; slave_sel=4'b1000; no REG states after the R address; data 0x11 then 0x22; final ack=1; byte_cnt=2.
- Address miss: address 0x55, slave NACK -> slave_sel=0, ack=1, state holds SLAVE_ADDR_ACK (18) through 9 further SCL pulses, then STOP -> IDLE.
- Mid-byte STOP: STOP after 3 data bits -> bus_error_o and stop_o pulse in the same cycle, no data_valid, state goes STOP then IDLE.
- Overflow: 130 acked data bytes -> byte_cnt saturates at 128, overflow_o set on the 129th byte, 130 data_valid pulses.
- Reset mid-frame: areset asserted during DATA_4 -> all outputs cleared immediately, state_o=1. After release, a following STOP produces no stop_o pulse.

Source files
------------

// File: rtl/i2c_bus_decoder.sv
// Passive I2C bus decoder: oversamples SCL/SDA, detects START/STOP conditions and
// tracks the frame position, emitting per-field capture strobes.
module i2c_bus_decoder #(
  parameter int SLAVE_ADDRESS_WIDTH    = 7,
  parameter int REGISTER_ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH             = 8,
  parameter int MAXIMUM_BYTES          = 128,
  parameter logic [SLAVE_ADDRESS_WIDTH-1:0] SLAVE0_ADDRESS = 7'h68,
  parameter logic [SLAVE_ADDRESS_WIDTH-1:0] SLAVE1_ADDRESS = 7'h6C,
  parameter logic [SLAVE_ADDRESS_WIDTH-1:0] SLAVE2_ADDRESS = 7'h7C,
  parameter logic [SLAVE_ADDRESS_WIDTH-1:0] SLAVE3_ADDRESS = 7'h4C
) (
  input  logic                              pclk,
  input  logic                              areset,
  input  logic                              scl_i,
  input  logic                              sda_i,
  output logic [5:0]                        state_o,
  output logic                              start_o,
  output logic                              restart_o,
  output logic                              stop_o,
  output logic [SLAVE_ADDRESS_WIDTH-1:0]    slave_addr_o,
  output logic                              rw_o,
  output logic                              addr_valid_o,
  output logic [3:0]                        slave_sel_o,
  output logic [REGISTER_ADDRESS_WIDTH-1:0] reg_addr_o,
  output logic                              reg_valid_o,
  output logic [DATA_WIDTH-1:0]             data_o,
  output logic                              data_valid_o,
  output logic [7:0]                        byte_cnt_o,
  output logic                              ack_o,
  output logic                              ack_valid_o,
  output logic                              bus_error_o,
  output logic                              overflow_o
);

  typedef enum logic [5:0] {
    ST_IDLE           = 6'd1,
    ST_SLAVE_ADDR_0   = 6'd10,
    ST_SLAVE_ADDR_1   = 6'd11,
    ST_SLAVE_ADDR_2   = 6'd12,
    ST_SLAVE_ADDR_3   = 6'd13,
    ST_SLAVE_ADDR_4   = 6'd14,
    ST_SLAVE_ADDR_5   = 6'd15,
    ST_SLAVE_ADDR_6   = 6'd16,
    ST_RD_WR          = 6'd17,
    ST_SLAVE_ADDR_ACK = 6'd18,
    ST_REG_ADDR_0     = 6'd19,
    ST_REG_ADDR_1     = 6'd20,
    ST_REG_ADDR_2     = 6'd21,
    ST_REG_ADDR_3     = 6'd22,
    ST_REG_ADDR_4     = 6'd23,
    ST_REG_ADDR_5     = 6'd24,
    ST_REG_ADDR_6     = 6'd25,
    ST_REG_ADDR_7     = 6'd26,
    ST_REG_ADDR_ACK   = 6'd27,
    ST_DATA_0         = 6'd28,
    ST_DATA_1         = 6'd29,
    ST_DATA_2         = 6'd30,
    ST_DATA_3         = 6'd31,
    ST_DATA_4         = 6'd32,
    ST_DATA_5         = 6'd33,
    ST_DATA_6         = 6'd34,
    ST_DATA_7         = 6'd35,
    ST_DATA_ACK       = 6'd36,
    ST_STOP           = 6'd39
  } i2c_fsm_state_e;

  // States in which a START/STOP cuts a field short.
  function automatic logic in_field(input i2c_fsm_state_e st);
    case (st)
      ST_SLAVE_ADDR_0, ST_SLAVE_ADDR_1, ST_SLAVE_ADDR_2, ST_SLAVE_ADDR_3,
      ST_SLAVE_ADDR_4, ST_SLAVE_ADDR_5, ST_SLAVE_ADDR_6, ST_RD_WR,
      ST_REG_ADDR_0, ST_REG_ADDR_1, ST_REG_ADDR_2, ST_REG_ADDR_3,
      ST_REG_ADDR_4, ST_REG_ADDR_5, ST_REG_ADDR_6, ST_REG_ADDR_7,
      ST_DATA_1, ST_DATA_2, ST_DATA_3, ST_DATA_4,
      ST_DATA_5, ST_DATA_6, ST_DATA_7: in_field = 1'b1;
      default:                         in_field = 1'b0;
    endcase
  endfunction

  logic           scl_meta_r;
  logic           sda_meta_r;
  logic           scl_s;
  logic           sda_s;
  logic           scl_p;
  logic           sda_p;
  logic           start_ev_s;
  logic           stop_ev_s;
  logic           rise_ev_s;
  logic [3:0]     match_s;
  logic [7:0]     shift_r;
  logic           hold_r;
  i2c_fsm_state_e state_r;

  // Two-flop synchronizers plus previous-sample flops; idle bus level is high.
  always_ff @(posedge pclk or posedge areset) begin
    if (areset) begin
      scl_meta_r <= 1'b1;
      sda_meta_r <= 1'b1;
      scl_s      <= 1'b1;
      sda_s      <= 1'b1;
      scl_p      <= 1'b1;
      sda_p      <= 1'b1;
    end else begin
      scl_meta_r <= scl_i;
      sda_meta_r <= sda_i;
      scl_s      <= scl_meta_r;
      sda_s      <= sda_meta_r;
      scl_p      <= scl_s;
      sda_p      <= sda_s;
    end
  end

  // An SCL change in the same sample masks any SDA change, so START/STOP need SCL high twice.
  assign start_ev_s = scl_s & scl_p & sda_p & ~sda_s;
  assign stop_ev_s  = scl_s & scl_p & ~sda_p & sda_s;
  assign rise_ev_s  = ~scl_p & scl_s;

  assign match_s = {shift_r[SLAVE_ADDRESS_WIDTH-1:0] == SLAVE3_ADDRESS,
                    shift_r[SLAVE_ADDRESS_WIDTH-1:0] == SLAVE2_ADDRESS,
                    shift_r[SLAVE_ADDRESS_WIDTH-1:0] == SLAVE1_ADDRESS,
                    shift_r[SLAVE_ADDRESS_WIDTH-1:0] == SLAVE0_ADDRESS};

  assign state_o = state_r;

  // Frame FSM with registered strobes and captured fields.
  always_ff @(posedge pclk or posedge areset) begin
    if (areset) begin
      state_r      <= ST_IDLE;
      hold_r       <= 1'b0;
      shift_r      <= 8'd0;
      start_o      <= 1'b0;
      restart_o    <= 1'b0;
      stop_o       <= 1'b0;
      slave_addr_o <= '0;
      rw_o         <= 1'b0;
      addr_valid_o <= 1'b0;
      slave_sel_o  <= 4'b0000;
      reg_addr_o   <= '0;
      reg_valid_o  <= 1'b0;
      data_o       <= '0;
      data_valid_o <= 1'b0;
      byte_cnt_o   <= 8'd0;
      ack_o        <= 1'b0;
      ack_valid_o  <= 1'b0;
      bus_error_o  <= 1'b0;
      overflow_o   <= 1'b0;
    end else begin
      start_o      <= 1'b0;
      restart_o    <= 1'b0;
      stop_o       <= 1'b0;
      addr_valid_o <= 1'b0;
      reg_valid_o  <= 1'b0;
      data_valid_o <= 1'b0;
      ack_valid_o  <= 1'b0;
      bus_error_o  <= 1'b0;
      if (start_ev_s) begin
        start_o     <= 1'b1;
        restart_o   <= (state_r != ST_IDLE) && (state_r != ST_STOP);
        bus_error_o <= in_field(state_r);
        state_r     <= ST_SLAVE_ADDR_0;
        byte_cnt_o  <= 8'd0;
        overflow_o  <= 1'b0;
        hold_r      <= 1'b0;
      end else if (stop_ev_s) begin
        if (state_r != ST_IDLE) begin
          stop_o      <= 1'b1;
          bus_error_o <= in_field(state_r);
          state_r     <= ST_STOP;
          hold_r      <= 1'b0;
        end else begin
          state_r <= state_r;
        end
      end else if (state_r == ST_STOP) begin
        state_r <= ST_IDLE;
      end else if (rise_ev_s && !hold_r) begin
        case (state_r)
          ST_IDLE: begin
            state_r <= ST_IDLE;
          end
          ST_SLAVE_ADDR_0, ST_SLAVE_ADDR_1, ST_SLAVE_ADDR_2, ST_SLAVE_ADDR_3,
          ST_SLAVE_ADDR_4, ST_SLAVE_ADDR_5, ST_SLAVE_ADDR_6,
          ST_REG_ADDR_0, ST_REG_ADDR_1, ST_REG_ADDR_2, ST_REG_ADDR_3,
          ST_REG_ADDR_4, ST_REG_ADDR_5, ST_REG_ADDR_6,
          ST_DATA_0, ST_DATA_1, ST_DATA_2, ST_DATA_3,
          ST_DATA_4, ST_DATA_5, ST_DATA_6: begin
            shift_r <= {shift_r[6:0], sda_s};
            state_r <= i2c_fsm_state_e'(state_r + 6'd1);
          end
          ST_RD_WR: begin
            rw_o         <= sda_s;
            slave_addr_o <= shift_r[SLAVE_ADDRESS_WIDTH-1:0];
            slave_sel_o  <= match_s;
            addr_valid_o <= 1'b1;
            state_r      <= ST_SLAVE_ADDR_ACK;
          end
          ST_REG_ADDR_7: begin
            reg_addr_o  <= {shift_r[REGISTER_ADDRESS_WIDTH-2:0], sda_s};
            reg_valid_o <= 1'b1;
            state_r     <= ST_REG_ADDR_ACK;
          end
          ST_DATA_7: begin
            data_o       <= {shift_r[DATA_WIDTH-2:0], sda_s};
            data_valid_o <= 1'b1;
            if (byte_cnt_o == 8'(MAXIMUM_BYTES)) begin
              overflow_o <= 1'b1;
            end else begin
              byte_cnt_o <= byte_cnt_o + 8'd1;
            end
            state_r <= ST_DATA_ACK;
          end
          ST_SLAVE_ADDR_ACK, ST_REG_ADDR_ACK, ST_DATA_ACK: begin
            // A NACK parks the FSM here until the next START or STOP.
            ack_o       <= sda_s;
            ack_valid_o <= 1'b1;
            if (sda_s) begin
              hold_r <= 1'b1;
            end else if (state_r == ST_SLAVE_ADDR_ACK && !rw_o) begin
              state_r <= ST_REG_ADDR_0;
            end else begin
              state_r <= ST_DATA_0;
            end
          end
          default: begin
            state_r <= ST_IDLE;
          end
        endcase
      end else begin
        state_r <= state_r;
      end
    end
  end

endmodule

// File: tb/tb_i2c_bus_decoder.sv
// Bench for i2c_bus_decoder: directed frames plus randomized traffic against a
// field-level behavioural model that is compared with every output each cycle.
module tb_i2c_bus_decoder;

  logic       pclk = 1'b0;
  logic       areset = 1'b1;
  logic       scl = 1'b1;
  logic       sda = 1'b1;
  logic [5:0] state_o;
  logic       start_o, restart_o, stop_o, rw_o, addr_valid_o, reg_valid_o;
  logic       data_valid_o, ack_o, ack_valid_o, bus_error_o, overflow_o;
  logic [6:0] slave_addr_o;
  logic [3:0] slave_sel_o;
  logic [7:0] reg_addr_o, data_o, byte_cnt_o;

  always #5 pclk = ~pclk;

  i2c_bus_decoder dut (
    .pclk(pclk), .areset(areset), .scl_i(scl), .sda_i(sda),
    .state_o(state_o), .start_o(start_o), .restart_o(restart_o), .stop_o(stop_o),
    .slave_addr_o(slave_addr_o), .rw_o(rw_o), .addr_valid_o(addr_valid_o),
    .slave_sel_o(slave_sel_o), .reg_addr_o(reg_addr_o), .reg_valid_o(reg_valid_o),
    .data_o(data_o), .data_valid_o(data_valid_o), .byte_cnt_o(byte_cnt_o),
    .ack_o(ack_o), .ack_valid_o(ack_valid_o), .bus_error_o(bus_error_o),
    .overflow_o(overflow_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (field + bit position) ----------------
  localparam int P_IDLE = 0, P_ADDR = 1, P_RW = 2, P_AACK = 3, P_REG = 4;
  localparam int P_RACK = 5, P_DATA = 6, P_DACK = 7, P_STOP = 8;

  int       m_phase, m_bit, m_acc;
  bit       m_hold;
  bit [3:0] hs, hd;
  int       e_addr, e_reg, e_data, e_cnt;
  bit [3:0] e_sel;
  bit       e_start, e_restart, e_stop, e_rw, e_av, e_rv, e_dv, e_ack, e_ackv, e_err, e_ovf;

  function automatic int state_code(input int ph, input int b);
    case (ph)
      P_ADDR:  return 10 + b;
      P_RW:    return 17;
      P_AACK:  return 18;
      P_REG:   return 19 + b;
      P_RACK:  return 27;
      P_DATA:  return 28 + b;
      P_DACK:  return 36;
      P_STOP:  return 39;
      default: return 1;
    endcase
  endfunction

  function automatic bit [3:0] sel_of(input int a);
    case (a)
      'h68:    return 4'b0001;
      'h6C:    return 4'b0010;
      'h7C:    return 4'b0100;
      'h4C:    return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction

  always @(posedge pclk or posedge areset) begin : mdl
    bit cs, cp, ds, dp, ev_start, ev_stop, ev_rise, inf;
    int width;
    if (areset) begin
      hs = 4'hF; hd = 4'hF;
      m_phase = P_IDLE; m_bit = 0; m_acc = 0; m_hold = 0;
      e_addr = 0; e_reg = 0; e_data = 0; e_cnt = 0; e_sel = 4'b0000;
      e_start = 0; e_restart = 0; e_stop = 0; e_rw = 0; e_av = 0; e_rv = 0;
      e_dv = 0; e_ack = 0; e_ackv = 0; e_err = 0; e_ovf = 0;
    end else begin
      // Pin levels two and three samples back decide this cycle's bus condition.
      hs = {hs[2:0], scl};
      hd = {hd[2:0], sda};
      cs = hs[2]; cp = hs[3]; ds = hd[2]; dp = hd[3];
      ev_start = cs && cp && dp && !ds;
      ev_stop  = cs && cp && !dp && ds;
      ev_rise  = !cp && cs;
      e_start = 0; e_restart = 0; e_stop = 0; e_av = 0; e_rv = 0;
      e_dv = 0; e_ackv = 0; e_err = 0;
      inf = (m_phase == P_ADDR) || (m_phase == P_RW) || (m_phase == P_REG) ||
            (m_phase == P_DATA && m_bit != 0);
      if (ev_start) begin
        e_start = 1;
        e_restart = (m_phase != P_IDLE) && (m_phase != P_STOP);
        e_err = inf;
        m_phase = P_ADDR; m_bit = 0; m_acc = 0; m_hold = 0;
        e_cnt = 0; e_ovf = 0;
      end else if (ev_stop) begin
        if (m_phase != P_IDLE) begin
          e_stop = 1; e_err = inf; m_phase = P_STOP; m_hold = 0;
        end
      end else if (m_phase == P_STOP) begin
        m_phase = P_IDLE;
      end else if (ev_rise && !m_hold) begin
        case (m_phase)
          P_ADDR, P_REG, P_DATA: begin
            m_acc = ((m_acc << 1) | int'(ds)) & 255;
            m_bit++;
            width = (m_phase == P_ADDR) ? 7 : 8;
            if (m_bit == width) begin
              if (m_phase == P_ADDR) begin
                m_phase = P_RW;
              end else if (m_phase == P_REG) begin
                e_reg = m_acc; e_rv = 1; m_phase = P_RACK;
              end else begin
                e_data = m_acc; e_dv = 1;
                if (e_cnt == 128) e_ovf = 1;
                else e_cnt++;
                m_phase = P_DACK;
              end
            end
          end
          P_RW: begin
            e_rw = ds; e_addr = m_acc; e_av = 1; e_sel = sel_of(m_acc);
            m_phase = P_AACK;
          end
          P_AACK, P_RACK, P_DACK: begin
            e_ack = ds; e_ackv = 1;
            if (ds) m_hold = 1;
            else begin
              m_phase = (m_phase == P_AACK && !e_rw) ? P_REG : P_DATA;
              m_bit = 0; m_acc = 0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge pclk) begin
    chk("state_o", state_o, state_code(m_phase, m_bit));
    chk("start_o", start_o, e_start);
    chk("restart_o", restart_o, e_restart);
    chk("stop_o", stop_o, e_stop);
    chk("slave_addr_o", slave_addr_o, e_addr);
    chk("rw_o", rw_o, e_rw);
    chk("addr_valid_o", addr_valid_o, e_av);
    chk("slave_sel_o", slave_sel_o, e_sel);
    chk("reg_addr_o", reg_addr_o, e_reg);
    chk("reg_valid_o", reg_valid_o, e_rv);
    chk("data_o", data_o, e_data);
    chk("data_valid_o", data_valid_o, e_dv);
    chk("byte_cnt_o", byte_cnt_o, e_cnt);
    chk("ack_o", ack_o, e_ack);
    chk("ack_valid_o", ack_valid_o, e_ackv);
    chk("bus_error_o", bus_error_o, e_err);
    chk("overflow_o", overflow_o, e_ovf);
  end

  // Pulse tallies of the DUT, used as actuals for the directed checks.
  int  n_restart = 0, n_stop = 0, n_rv = 0, n_dv = 0, n_ackv = 0, n_errstop = 0, n_start = 0;
  int  dv_at_ovf = 0;
  int  last_data = 0, prev_data = 0;
  bit  ovf_prev = 0;
  always @(negedge pclk) begin
    if (start_o) n_start++;
    if (restart_o) n_restart++;
    if (stop_o) n_stop++;
    if (reg_valid_o) n_rv++;
    if (ack_valid_o) n_ackv++;
    if (bus_error_o && stop_o) n_errstop++;
    if (data_valid_o) begin
      n_dv++;
      prev_data = last_data;
      last_data = int'(data_o);
      if (overflow_o && !ovf_prev) dv_at_ovf = n_dv;
    end
    ovf_prev = overflow_o;
  end

  // ---------------- bus drivers ----------------
  int hp = 4;
  bit rnd_edges = 0;

  task automatic tick(input int n);
    repeat (n) @(negedge pclk);
  endtask

  task automatic do_start();
    sda = 1'b1; tick(hp);
    scl = 1'b1; tick(hp);
    sda = 1'b0; tick(hp);
    scl = 1'b0; tick(hp);
  endtask

  task automatic do_stop();
    sda = 1'b0; tick(hp);
    scl = 1'b1; tick(hp);
    sda = 1'b1; tick(hp);
  endtask

  task automatic send_bit(input logic b);
    if (rnd_edges && $urandom_range(0, 9) == 0) begin
      sda = b; scl = 1'b1;
    end else begin
      sda = b; tick(hp);
      scl = 1'b1;
    end
    tick(hp);
    scl = 1'b0; tick(2);
  endtask

  task automatic send_bits(input int v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(logic'((v >> i) & 1));
  endtask

  task automatic xfer(input int v, input logic ack);
    send_bits(v, 8);
    send_bit(ack);
  endtask

  initial begin
    int base_dv, base_rv, base_ackv, base_stop, base_restart, base_es, base_start;
    int nb, v, addr;
    bit brk;

    tick(2);
    chk("reset_state", state_o, 6'd1);
    chk("reset_outputs", {start_o, restart_o, stop_o, slave_addr_o, rw_o, addr_valid_o,
        slave_sel_o, reg_addr_o, reg_valid_o, data_o, data_valid_o, byte_cnt_o, ack_o,
        ack_valid_o, bus_error_o, overflow_o}, 64'd0);
    areset = 1'b0;
    tick(4);

    // Write frame.
    base_ackv = n_ackv; base_stop = n_stop; base_dv = n_dv; base_rv = n_rv;
    do_start();
    xfer('h68 << 1, 1'b0);
    xfer('hA5, 1'b0);
    xfer('h3C, 1'b0);
    do_stop();
    tick(6);
    chk("wr_slave_addr", slave_addr_o, 7'h68);
    chk("wr_rw", rw_o, 1'b0);
    chk("wr_sel", slave_sel_o, 4'b0001);
    chk("wr_reg_addr", reg_addr_o, 8'hA5);
    chk("wr_data", data_o, 8'h3C);
    chk("wr_byte_cnt", byte_cnt_o, 8'd1);
    chk("wr_ack_pulses", n_ackv - base_ackv, 3);
    chk("wr_ack", ack_o, 1'b0);
    chk("wr_stop_pulses", n_stop - base_stop, 1);
    chk("wr_data_pulses", n_dv - base_dv, 1);
    chk("wr_end_state", state_o, 6'd1);

    // Write register pointer, repeated START, read two bytes.
    base_restart = n_restart; base_dv = n_dv; base_rv = n_rv;
    do_start();
    xfer('h4C << 1, 1'b0);
    xfer('h10, 1'b0);
    do_start();
    xfer(('h4C << 1) | 1, 1'b0);
    xfer('h11, 1'b0);
    xfer('h22, 1'b1);
    do_stop();
    tick(6);
    chk("rd_restart_pulses", n_restart - base_restart, 1);
    chk("rd_sel", slave_sel_o, 4'b1000);
    chk("rd_rw", rw_o, 1'b1);
    chk("rd_reg_pulses", n_rv - base_rv, 1);
    chk("rd_data_first", prev_data, 8'h11);
    chk("rd_data_last", last_data, 8'h22);
    chk("rd_final_ack", ack_o, 1'b1);
    chk("rd_byte_cnt", byte_cnt_o, 8'd2);

    // Address miss with NACK, then further clocks are ignored.
    do_start();
    xfer('h55 << 1, 1'b1);
    repeat (9) send_bit(logic'($urandom_range(0, 1)));
    tick(6);
    chk("miss_state", state_o, 6'd18);
    chk("miss_sel", slave_sel_o, 4'b0000);
    chk("miss_ack", ack_o, 1'b1);
    do_stop();
    tick(6);
    chk("miss_end_state", state_o, 6'd1);

    // STOP after three data bits.
    base_es = n_errstop; base_dv = n_dv;
    do_start();
    xfer('h68 << 1, 1'b0);
    xfer('h01, 1'b0);
    send_bits(3'b101, 3);
    do_stop();
    tick(6);
    chk("mid_err_with_stop", n_errstop - base_es, 1);
    chk("mid_no_data", n_dv - base_dv, 0);
    chk("mid_end_state", state_o, 6'd1);

    // SCL and SDA moving together are treated as SCL edges only.
    base_start = n_start; base_stop = n_stop;
    scl = 1'b0; sda = 1'b0; tick(hp);
    chk("simul_no_start", n_start - base_start, 0);
    scl = 1'b1; sda = 1'b1; tick(hp);
    do_start();
    xfer('h6C << 1, 1'b0);
    sda = 1'b0; tick(hp);
    scl = 1'b1; sda = 1'b1; tick(hp);
    chk("simul_no_stop", n_stop - base_stop, 0);
    chk("simul_state", state_o, 6'd20);
    scl = 1'b0; tick(2);
    do_stop();
    tick(6);

    // 130 acknowledged data bytes.
    base_dv = n_dv;
    do_start();
    xfer('h7C << 1, 1'b0);
    xfer('h00, 1'b0);
    repeat (130) xfer(int'($urandom_range(0, 255)), 1'b0);
    do_stop();
    tick(6);
    chk("ovf_byte_cnt", byte_cnt_o, 8'd128);
    chk("ovf_flag", overflow_o, 1'b1);
    chk("ovf_data_pulses", n_dv - base_dv, 130);
    chk("ovf_first_byte", dv_at_ovf - base_dv, 129);

    // Reset in the middle of a data byte.
    do_start();
    xfer('h68 << 1, 1'b0);
    xfer('h20, 1'b0);
    send_bits(4'b1111, 4);
    tick(4);
    chk("pre_reset_state", state_o, 6'd32);
    #2 areset = 1'b1;
    #1;
    chk("async_reset_state", state_o, 6'd1);
    chk("async_reset_outputs", {start_o, restart_o, stop_o, slave_addr_o, rw_o, addr_valid_o,
        slave_sel_o, reg_addr_o, reg_valid_o, data_o, data_valid_o, byte_cnt_o, ack_o,
        ack_valid_o, bus_error_o, overflow_o}, 64'd0);
    tick(3);
    areset = 1'b0;
    tick(4);
    base_stop = n_stop;
    do_stop();
    tick(6);
    chk("post_reset_no_stop", n_stop - base_stop, 0);
    chk("post_reset_state", state_o, 6'd1);

    // Randomized traffic, checked cycle by cycle against the model.
    rnd_edges = 1;
    for (int f = 0; f < 40; f++) begin
      hp = int'($urandom_range(4, 7));
      do_start();
      nb = int'($urandom_range(1, 4));
      brk = 0;
      for (int b = 0; b < nb && !brk; b++) begin
        if (b == 0) begin
          case ($urandom_range(0, 4))
            0: addr = 'h68;
            1: addr = 'h6C;
            2: addr = 'h7C;
            3: addr = 'h4C;
            default: addr = int'($urandom_range(0, 127));
          endcase
          v = (addr << 1) | int'($urandom_range(0, 1));
        end else begin
          v = int'($urandom_range(0, 255));
        end
        if ($urandom_range(0, 7) == 0) begin
          send_bits(v, int'($urandom_range(1, 7)));
          brk = 1;
        end else begin
          xfer(v, logic'($urandom_range(0, 5) == 0));
        end
      end
      if ($urandom_range(0, 2) != 0) do_stop();
    end
    do_stop();
    tick(8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
